axil_uart_tx_arbiter: RTL
=========================

AXIL_UART_TX_ARBITER -- requirements
Module: axil_uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of byte requesters (2..8).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0, bridge base address; TXDATA=BASE+0x00, RXDATA=BASE+0x04, STATUS=BASE+0x08 (bit0 tx_busy, bit1 rx_valid).
REQ-003 SHALL have ports: clk in 1 clock; resetn in 1 asynchronous active-low reset.
REQ-004 SHALL have ports: req_valid in NUM_REQ, per-requester byte pending; req_data in 8*NUM_REQ, byte i at [8i+7:8i]; req_ack out NUM_REQ, one-cycle done pulse; req_err out 1, qualifies req_ack (bresp not OKAY).
REQ-005 SHALL have ports: rx_data out 8, received byte; rx_valid out 1; rx_ready in 1; err_cnt out 8, saturating count of non-OKAY responses.
REQ-006 SHALL have AXI4-Lite master ports, 32-bit addr/data: m_axi_awaddr/awvalid out, awready in; wdata/wvalid out, wready in; bresp in 2, bvalid in, bready out; araddr/arvalid out, arready in; rdata in 32, rresp in 2, rvalid in, rready out.

Function
REQ-007 SHALL implement FSM states IDLE, POLL_AR, POLL_R, RX_AR, RX_R, WR, WR_B.
REQ-008 IDLE SHALL go to POLL_AR next cycle when any req_valid is high or rx holding register is empty; else remain.
REQ-009 POLL_AR SHALL drive araddr=STATUS, arvalid=1 until arready; then POLL_R with rready=1 until rvalid.
REQ-010 In POLL_R with rvalid: rresp!=OKAY -> err_cnt+1, IDLE; else if rdata[1]=1 and holding empty -> RX_AR (RX drain has priority over TX); else if rdata[0]=0 and any req_valid -> latch grant and byte, WR; else IDLE.
REQ-011 Grant SHALL be round-robin: first requester with req_valid at or after pointer, searching upward with wrap from NUM_REQ-1 to 0; pointer resets to 0.
REQ-012 Grant and byte SHALL be latched on POLL_R exit and held constant through WR_B; later req_valid changes SHALL NOT affect the transaction.
REQ-013 WR SHALL assert awvalid (awaddr=TXDATA) and wvalid (wdata={24'h0,byte}) in the same cycle; each SHALL drop independently after its own handshake; go to WR_B when both handshakes done (same or different cycles).
REQ-014 WR_B SHALL assert bready; on bvalid pulse req_ack[grant] for exactly one cycle, req_err=(bresp!=OKAY), pointer=grant+1 mod NUM_REQ, err_cnt+1 if error, then IDLE.
REQ-015 RX_AR SHALL read RXDATA (same handshake as REQ-009); RX_R on rvalid: OKAY -> rx_data=rdata[7:0], rx_valid=1; else err_cnt+1, holding unchanged; then IDLE.
REQ-016 rx_valid SHALL stay high, rx_data stable, until rx_ready sampled high; clears next cycle; holding empty when rx_valid=0.
REQ-017 All AXI valids SHALL remain high with stable address/data until handshake; at most one outstanding transaction; bready/rready low outside WR_B/POLL_R/RX_R.
REQ-018 A TXDATA write SHALL only follow a STATUS read issued after the previous write's B handshake returning tx_busy=0.
REQ-019 err_cnt SHALL saturate at 8'hFF.

Reset
REQ-020 On resetn low, immediately and mid-transaction: FSM=IDLE, all AXI valid/ready outputs 0, addr/data 0, req_ack 0, req_err 0, rx_valid 0, rx_data 0, err_cnt 0, pointer 0.
REQ-021 Outputs SHALL leave reset values no earlier than the first clk edge after resetn deasserts.

Verification
REQ-022 req_valid=4'b0001, data 0x41, STATUS=0x0 -> one TXDATA write wdata=0x41, req_ack[0] one cycle, req_err=0.
REQ-023 req_valid=4'b1111 held, status idle -> write order 0,1,2,3,0; each req_ack single pulse.
REQ-024 STATUS=0x3, req_valid=4'b0010 -> RXDATA read first, rx_data=rdata[7:0], rx_valid held until rx_ready; next STATUS read then write.
REQ-025 awready 3 cycles before wready; STATUS tx_busy=1 twice -> no write until tx_busy=0; aw/w each single handshake.
REQ-026 bresp=SLVERR; rresp=SLVERR on poll -> req_ack with req_err=1, err_cnt=2; resetn low in WR -> all outputs reset values.

Source files
------------

// File: rtl/axil_uart_tx_arbiter.sv
// Round-robin arbiter that funnels requester bytes into a UART bridge over AXI4-Lite.
// It polls STATUS before every transfer and drains received bytes ahead of transmit work.
module axil_uart_tx_arbiter #(
  parameter int          NUM_REQ   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic                   req_err,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic [7:0]             err_cnt,
  output logic [2:0]             dbg_state,
  output logic [31:0]            m_axi_awaddr,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,
  output logic [31:0]            m_axi_wdata,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,
  input  logic [1:0]             m_axi_bresp,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready,
  output logic [31:0]            m_axi_araddr,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  input  logic [31:0]            m_axi_rdata,
  input  logic [1:0]             m_axi_rresp,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready
);

  // Handshake rule: a beat transfers on a rising clk edge where valid and ready are both high;
  // valid never depends on ready and holds address/data steady until that edge.

  localparam int          IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IW:0] NUM_W    = (IW+1)'(NUM_REQ);
  localparam logic [IW-1:0] LAST   = IW'(NUM_REQ - 1);
  localparam logic [31:0] TXDATA_A = BASE_ADDR + 32'h0;
  localparam logic [31:0] RXDATA_A = BASE_ADDR + 32'h4;
  localparam logic [31:0] STATUS_A = BASE_ADDR + 32'h8;

  typedef enum logic [2:0] {IDLE, POLL_AR, POLL_R, RX_AR, RX_R, WR, WR_B} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, grant, rr_idx, rr_off;
  logic [IW:0]     rr_sum;
  logic            rr_found;
  logic [2*NUM_REQ-1:0] rr_dbl;
  logic [7:0]      tx_byte;
  logic            aw_done, w_done, aw_hs, w_hs, err_inc;
  logic            unused_rdata;

  assign unused_rdata = ^m_axi_rdata[31:8];

  // Rotate the request vector so the pointer lands at bit 0, then take the lowest set bit.
  always_comb begin
    rr_dbl   = {req_valid, req_valid} >> ptr;
    rr_found = |req_valid;
    rr_off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rr_dbl[k]) rr_off = IW'(k);
    end
    rr_sum = {1'b0, ptr} + {1'b0, rr_off};
    if (rr_sum >= NUM_W) rr_sum = rr_sum - NUM_W;
    rr_idx = rr_sum[IW-1:0];
  end

  assign aw_hs   = m_axi_awvalid && m_axi_awready;
  assign w_hs    = m_axi_wvalid && m_axi_wready;
  assign err_inc = (((state == POLL_R) || (state == RX_R)) && m_axi_rvalid && (m_axi_rresp != 2'b00)) ||
                   ((state == WR_B) && m_axi_bvalid && (m_axi_bresp != 2'b00));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rr_found || !rx_valid) state_nxt = POLL_AR;
      POLL_AR: if (m_axi_arready) state_nxt = POLL_R;
      POLL_R:  if (m_axi_rvalid) begin
                 if (m_axi_rresp != 2'b00)                state_nxt = IDLE;
                 else if (m_axi_rdata[1] && !rx_valid)     state_nxt = RX_AR;
                 else if (!m_axi_rdata[0] && rr_found)     state_nxt = WR;
                 else                                      state_nxt = IDLE;
               end
      RX_AR:   if (m_axi_arready) state_nxt = RX_R;
      RX_R:    if (m_axi_rvalid) state_nxt = IDLE;
      WR:      if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_B;
      WR_B:    if (m_axi_bvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      ptr      <= '0;
      grant    <= '0;
      tx_byte  <= 8'h00;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      req_ack  <= '0;
      req_err  <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      err_cnt  <= 8'h00;
    end else begin
      state   <= state_nxt;
      req_ack <= '0;
      req_err <= 1'b0;
      if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if ((state == POLL_R) && (state_nxt == WR)) begin
        grant   <= rr_idx;
        tx_byte <= req_data[8*rr_idx +: 8];
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (state == WR) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if ((state == RX_R) && m_axi_rvalid && (m_axi_rresp == 2'b00)) begin
        rx_data  <= m_axi_rdata[7:0];
        rx_valid <= 1'b1;
      end
      if ((state == WR_B) && m_axi_bvalid) begin
        req_ack <= NUM_REQ'(1) << grant;
        req_err <= (m_axi_bresp != 2'b00);
        ptr     <= (grant == LAST) ? '0 : grant + IW'(1);
      end
    end
  end

  assign dbg_state     = state;
  assign m_axi_arvalid = (state == POLL_AR) || (state == RX_AR);
  assign m_axi_araddr  = (state == POLL_AR) ? STATUS_A : (state == RX_AR) ? RXDATA_A : 32'h0;
  assign m_axi_rready  = (state == POLL_R) || (state == RX_R);
  assign m_axi_awvalid = (state == WR) && !aw_done;
  assign m_axi_awaddr  = m_axi_awvalid ? TXDATA_A : 32'h0;
  assign m_axi_wvalid  = (state == WR) && !w_done;
  assign m_axi_wdata   = m_axi_wvalid ? {24'h0, tx_byte} : 32'h0;
  assign m_axi_bready  = (state == WR_B);

endmodule
